// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM handshake states, arbiter states, beat counter width.
package cpu_types_pkg;

    localparam int BEATW = 3;
    localparam int WORDW = 32;

    typedef logic [WORDW-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

    // Index of the final beat of a burst, truncated to the beat counter width.
    function automatic logic [BEATW-1:0] last_beat(input int burst);
        logic [BEATW-1:0] idx;
        idx = BEATW'(burst - 1);
        return idx;
    endfunction

endpackage

// File: rtl/mem_arbiter_prio.sv
// Next-grant decision taken from IDLE; purely combinational.
// Dcache wins ties unless it held the previous grant, so neither side starves.
module arb_prio
    import cpu_types_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  logic       lastd,
    output arb_state_t gnt_nxt
);

    always_comb begin
        gnt_nxt = IDLE;
        if (d_req && !(i_req && lastd)) begin
            gnt_nxt = DGNT;
        end else if (i_req) begin
            gnt_nxt = IGNT;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache fills and dcache block transfers.
// Grant is held for a whole burst; the loser simply sees wait=1 and retries later.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DBURST = 2,
    parameter int IBURST = 1,
    parameter int AW     = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    output logic          iwait,
    output logic [AW-1:0] iload,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [AW-1:0] dstore,
    output logic          dwait,
    output logic [AW-1:0] dload,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [AW-1:0] ramstore,
    input  logic [AW-1:0] ramload,
    input  logic [1:0]    ramstate,
    output logic          memerr
);

    if (DBURST < 1 || DBURST > 8 || IBURST < 1 || IBURST > 8) begin : g_bad_burst
        $error("mem_arbiter: burst lengths must be 1..8");
    end

    localparam logic [BEATW-1:0] D_LAST = last_beat(DBURST);
    localparam logic [BEATW-1:0] I_LAST = last_beat(IBURST);

    arb_state_t       state_q, state_d;
    arb_state_t       gnt_nxt;
    logic [BEATW-1:0] cnt_q, cnt_d;
    logic             lastd_q, lastd_d;
    logic             memerr_q, memerr_d;
    logic             d_req;
    ramstate_t        rs;

    assign d_req  = dREN | dWEN;
    assign rs     = ramstate_t'(ramstate);
    assign memerr = memerr_q;

    arb_prio u_prio (
        .i_req   (iREN),
        .d_req   (d_req),
        .lastd   (lastd_q),
        .gnt_nxt (gnt_nxt)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lastd_d  = lastd_q;
        memerr_d = memerr_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        case (state_q)
            IDLE: begin
                state_d = gnt_nxt;
                cnt_d   = '0;
            end

            DGNT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                // Dropping both enables ends the burst early; it still counts as a dcache turn.
                if (!d_req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    lastd_d = 1'b1;
                end else begin
                    case (rs)
                        ACCESS: begin
                            dwait = 1'b0;
                            dload = ramload;
                            if (cnt_q == D_LAST) begin
                                state_d = IDLE;
                                cnt_d   = '0;
                                lastd_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + BEATW'(1);
                            end
                        end
                        ERROR:   memerr_d = 1'b1;
                        default: ;
                    endcase
                end
            end

            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    lastd_d = 1'b0;
                end else begin
                    case (rs)
                        ACCESS: begin
                            iwait = 1'b0;
                            iload = ramload;
                            if (cnt_q == I_LAST) begin
                                state_d = IDLE;
                                cnt_d   = '0;
                                lastd_d = 1'b0;
                            end else begin
                                cnt_d = cnt_q + BEATW'(1);
                            end
                        end
                        ERROR:   memerr_d = 1'b1;
                        default: ;
                    endcase
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lastd_q  <= 1'b0;
            memerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lastd_q  <= lastd_d;
            memerr_q <= memerr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level owner/words-left model.
module tb_mem_arbiter;

    localparam int DB = 2;
    localparam int IB = 1;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, memerr;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: who owns the RAM, words still owed in the burst, fairness and error history.
    int m_owner;
    int m_left;
    bit m_lastd;
    bit m_memerr;

    always #5 CLK = ~CLK;

    mem_arbiter #(.DBURST(DB), .IBURST(IB), .AW(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_left   = 0;
        m_lastd  = 1'b0;
        m_memerr = 1'b0;
    endtask

    task automatic check_outputs();
        logic        e_iw, e_dw, e_ren, e_wen;
        logic [31:0] e_addr, e_store, e_il, e_dl;
        e_iw = 1'b1; e_dw = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
        e_addr = '0; e_store = '0; e_il = '0; e_dl = '0;
        if (m_owner == 2) begin
            e_ren = dREN; e_wen = dWEN; e_addr = daddr; e_store = dstore;
            if ((dREN || dWEN) && ramstate == 2'd2) begin
                e_dw = 1'b0; e_dl = ramload;
            end
        end else if (m_owner == 1) begin
            e_ren = iREN; e_addr = iaddr;
            if (iREN && ramstate == 2'd2) begin
                e_iw = 1'b0; e_il = ramload;
            end
        end
        check("iwait", iwait, e_iw);
        check("dwait", dwait, e_dw);
        check("ramREN", ramREN, e_ren);
        check("ramWEN", ramWEN, e_wen);
        check("ramaddr", ramaddr, e_addr);
        check("ramstore", ramstore, e_store);
        check("iload", iload, e_il);
        check("dload", dload, e_dl);
        check("memerr", memerr, m_memerr);
    endtask

    // Advance the model across one rising edge with the current inputs.
    task automatic model_step();
        bit d_req;
        d_req = dREN || dWEN;
        if (!nRST) begin
            model_reset();
        end else if (m_owner == 0) begin
            if (d_req && !(iREN && m_lastd)) begin
                m_owner = 2; m_left = DB;
            end else if (iREN) begin
                m_owner = 1; m_left = IB;
            end
        end else begin
            if (!(m_owner == 2 ? d_req : iREN)) begin
                m_lastd = (m_owner == 2);
                m_owner = 0;
            end else if (ramstate == 2'd2) begin
                m_left--;
                if (m_left == 0) begin
                    m_lastd = (m_owner == 2);
                    m_owner = 0;
                end
            end else if (ramstate == 2'd3) begin
                m_memerr = 1'b1;
            end
        end
    endtask

    // Inputs are set at posedge+1; outputs checked at posedge+3.
    task automatic cycle();
        #2;
        check_outputs();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input logic i, input logic r, input logic w);
        iREN = i; dREN = r; dWEN = w;
    endtask

    initial begin
        int iop, dop;
        model_reset();
        nRST = 1'b0;
        set_req(1'b1, 1'b0, 1'b1);
        iaddr = 32'h44; daddr = 32'h88; dstore = 32'hDEAD; ramload = 32'h1234;
        ramstate = 2'd2;
        @(posedge CLK); #1;
        cycle();
        cycle();
        nRST = 1'b1;
        set_req(1'b0, 1'b0, 1'b0);
        ramstate = 2'd0;
        cycle();

        // Single icache fill after two BUSY cycles.
        set_req(1'b1, 1'b0, 1'b0);
        iaddr = 32'h40; ramload = 32'h8C010004; ramstate = 2'd1;
        cycle(); cycle(); cycle();
        ramstate = 2'd2;
        cycle();
        check("fill_iload", iload, 32'h0);
        set_req(1'b0, 1'b0, 1'b0); ramstate = 2'd0;
        cycle();

        // Two-beat dcache read.
        set_req(1'b0, 1'b1, 1'b0);
        daddr = 32'h100; ramstate = 2'd2; ramload = 32'hA0A0_0001;
        cycle(); cycle();
        daddr = 32'h104; ramload = 32'hA0A0_0002;
        cycle();
        set_req(1'b0, 1'b0, 1'b0); ramstate = 2'd0;
        cycle();

        // Both requesting: alternation of grants, starting from lastd left by the read.
        set_req(1'b1, 1'b0, 1'b1);
        iaddr = 32'h200; daddr = 32'h300; dstore = 32'h5555_AAAA; ramstate = 2'd2;
        for (int k = 0; k < 10; k++) begin
            ramload = $urandom;
            cycle();
        end
        set_req(1'b0, 1'b0, 1'b0); ramstate = 2'd0;
        cycle();

        // ERROR during IGNT retries the word and latches memerr.
        set_req(1'b1, 1'b0, 1'b0);
        iaddr = 32'h80; ramload = 32'h0BAD_F00D; ramstate = 2'd0;
        cycle();
        ramstate = 2'd3; cycle();
        ramstate = 2'd2; cycle();
        set_req(1'b0, 1'b0, 1'b0); ramstate = 2'd0;
        cycle(); cycle();
        check("memerr_sticky", memerr, 1'b1);

        // Early release after one of two dcache beats, then an icache grant.
        set_req(1'b0, 1'b1, 1'b0);
        daddr = 32'h400; ramstate = 2'd2;
        cycle(); cycle();
        set_req(1'b1, 1'b0, 1'b0); iaddr = 32'h500; ramstate = 2'd0;
        cycle(); cycle();
        ramstate = 2'd2; cycle();
        set_req(1'b0, 1'b0, 1'b0);
        cycle();

        // Reset mid-DGNT drops enables immediately and clears memerr.
        set_req(1'b0, 1'b0, 1'b1); daddr = 32'h600; ramstate = 2'd1;
        cycle(); cycle();
        nRST = 1'b0;
        model_reset();
        #1;
        check("rst_ramWEN", ramWEN, 1'b0);
        check("rst_dwait", dwait, 1'b1);
        #1;
        @(posedge CLK); #1;
        cycle();
        nRST = 1'b1;
        cycle();
        check("rst_memerr", memerr, 1'b0);

        // Random traffic with sticky requests and a random RAM.
        iop = 0; dop = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) iop = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) dop = $urandom_range(0, 2);
            set_req(iop[0], dop == 1, dop == 2);
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            case ($urandom_range(0, 19))
                0, 1, 2:    ramstate = 2'd0;
                3, 4, 5, 6: ramstate = 2'd1;
                7:          ramstate = 2'd3;
                default:    ramstate = 2'd2;
            endcase
            if ($urandom_range(0, 299) == 0) begin
                nRST = 1'b0;
                model_reset();
                cycle();
                nRST = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
